// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute/write-back control for the 9-bit ALU.
// Holds an 8x9-bit register file, drives the ALU opcode/operands for one cycle
// per instruction and writes the ALU result back to R[rd].
module alu_sequencer #(
    parameter  int unsigned PC_W    = 8,
    parameter  int unsigned DATA_W  = 9,
    localparam int unsigned INSTR_W = 16,
    localparam int unsigned OP_W    = 4,
    localparam int unsigned RIDX_W  = 3,
    localparam int unsigned RET_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [OP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               halted,
    output logic               illegal,
    output logic [RET_W-1:0]   retired,
    input  logic [RIDX_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam int unsigned IMM_W = 6;
    localparam int unsigned NREG  = 8;

    localparam logic [OP_W-1:0] OP_AND  = 4'h0;
    localparam logic [OP_W-1:0] OP_OR   = 4'h1;
    localparam logic [OP_W-1:0] OP_NOT  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h3;
    localparam logic [OP_W-1:0] OP_MOV  = 4'h4;
    localparam logic [OP_W-1:0] OP_SLL  = 4'h5;
    localparam logic [OP_W-1:0] OP_SRL  = 4'h6;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h7;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h8;
    localparam logic [OP_W-1:0] OP_SUBI = 4'h9;
    localparam logic [OP_W-1:0] OP_MOVI = 4'hA;
    localparam logic [OP_W-1:0] OP_NOP  = 4'hB;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [RIDX_W-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic                imem_en_q, imem_en_d;
    logic                halted_q, halted_d;
    logic                illegal_q, illegal_d;
    logic [RET_W-1:0]    retired_q, retired_d;
    logic [DATA_W-1:0]   rf_q [NREG];

    logic                rf_we;
    logic                retire_inc;

    // Instruction fields, valid while in DECODE (memory data arrives then).
    logic [OP_W-1:0]     dec_op;
    logic [RIDX_W-1:0]   dec_rd;
    logic [RIDX_W-1:0]   dec_rs;
    logic [IMM_W-1:0]    dec_imm;
    logic [DATA_W-1:0]   imm_ext;

    assign dec_op  = imem_rdata[15:12];
    assign dec_rd  = imem_rdata[11:9];
    assign dec_rs  = imem_rdata[8:6];
    assign dec_imm = imem_rdata[5:0];
    assign imm_ext = DATA_W'(dec_imm);

    // Next-state, operand selection and bookkeeping.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rd_d       = rd_q;
        result_d   = result_q;
        alu_op_d   = OP_NOP;
        alu_a_d    = '0;
        alu_b_d    = '0;
        imem_en_d  = 1'b0;
        halted_d   = halted_q;
        illegal_d  = illegal_q;
        rf_we      = 1'b0;
        retire_inc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    imem_en_d = 1'b1;
                end
            end

            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                rd_d = dec_rd;
                pc_d = pc_q + PC_W'(1);
                case (dec_op)
                    OP_HALT: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
                    OP_AND, OP_OR, OP_ADD, OP_SUB: begin
                        state_d  = S_EXEC;
                        alu_op_d = dec_op;
                        alu_a_d  = rf_q[dec_rd];
                        alu_b_d  = rf_q[dec_rs];
                    end
                    OP_NOT, OP_MOV, OP_SLL, OP_SRL: begin
                        state_d  = S_EXEC;
                        alu_op_d = dec_op;
                        alu_a_d  = rf_q[dec_rs];
                    end
                    OP_ADDI, OP_SUBI: begin
                        state_d  = S_EXEC;
                        alu_op_d = dec_op;
                        alu_a_d  = rf_q[dec_rd];
                        alu_b_d  = imm_ext;
                    end
                    OP_MOVI: begin
                        state_d  = S_EXEC;
                        alu_op_d = dec_op;
                        alu_b_d  = imm_ext;
                    end
                    OP_NOP: begin
                        state_d    = S_FETCH;
                        imem_en_d  = 1'b1;
                        retire_inc = 1'b1;
                    end
                    default: begin
                        // C/D/E: retire as a no-op and flag it.
                        state_d    = S_FETCH;
                        imem_en_d  = 1'b1;
                        retire_inc = 1'b1;
                        illegal_d  = 1'b1;
                    end
                endcase
            end

            S_EXEC: begin
                result_d = alu_result;
                state_d  = S_WB;
            end

            S_WB: begin
                rf_we      = 1'b1;
                retire_inc = 1'b1;
                state_d    = S_FETCH;
                imem_en_d  = 1'b1;
            end

            S_HALT: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    halted_d  = 1'b0;
                    imem_en_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        retired_d = retired_q;
        if (retire_inc && (retired_q != {RET_W{1'b1}})) begin
            retired_d = retired_q + RET_W'(1);
        end
    end

    // State, datapath and register-file update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            rd_q      <= '0;
            result_q  <= '0;
            alu_op_q  <= OP_NOP;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            imem_en_q <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            alu_op_q  <= alu_op_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            imem_en_q <= imem_en_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
            if (rf_we) begin
                rf_q[rd_q] <= result_q;
            end
        end
    end

    assign imem_en   = imem_en_q;
    assign imem_addr = pc_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;
    assign dbg_data  = rf_q[dbg_sel];

endmodule
